// File: rtl/perceptron_bht_pkg.sv
// Shared types and defaults for the perceptron branch predictor.
package perceptron_bht_pkg;

    localparam int unsigned VLEN             = 32;
    localparam int unsigned INSTR_PER_FETCH  = 2;
    localparam bit          RVC              = 1'b1;
    localparam int unsigned PERCEPTRON_H     = 16;
    localparam int unsigned PERCEPTRON_W     = 8;
    localparam int unsigned PERCEPTRON_THETA = 44;

    typedef logic signed [PERCEPTRON_W-1:0] perceptron_weight_t;
    typedef perceptron_weight_t [PERCEPTRON_H:0] perceptron_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
        logic            mispredict;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

endpackage

// File: rtl/perceptron_bht_dot.sv
// Combinational signed dot product of one perceptron against a history vector.
module perceptron_dot #(
    parameter int unsigned H  = 16,
    parameter int unsigned W  = 8,
    parameter int unsigned YW = W + $clog2(H + 2)
) (
    input  logic [H:0][W-1:0]      weights,
    input  logic [H-1:0]           hist,
    output logic signed [YW-1:0]   y
);

    always_comb begin
        y = YW'($signed(weights[0]));
        for (int unsigned i = 0; i < H; i++) begin
            if (hist[i]) y = y + YW'($signed(weights[i+1]));
            else         y = y - YW'($signed(weights[i+1]));
        end
    end

endmodule

// File: rtl/perceptron_bht.sv
// Perceptron conditional-branch predictor with speculative/committed GHR and 2-stage training.
// Optional statistics counters are built when PERCEPTRON_BHT_STATS_EN is defined.
module perceptron_bht
    import perceptron_bht_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned GHR_LENGTH = PERCEPTRON_H,
    parameter int unsigned WEIGHT_W   = PERCEPTRON_W,
    parameter int unsigned THETA      = PERCEPTRON_THETA
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic                                   debug_mode_i,
    input  logic [VLEN-1:0]                        vpc_i,
    input  logic                                   spec_valid_i,
    input  logic                                   spec_taken_i,
    input  bht_update_t                            bht_update_i,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]  bht_prediction_o,
    output logic [31:0]                            stat_pred_o,
    output logic [31:0]                            stat_mispred_o,
    output logic [31:0]                            stat_train_o
);

    localparam int unsigned OFF    = RVC ? 1 : 2;
    localparam int unsigned SLOT_W = $clog2(INSTR_PER_FETCH);
    localparam int unsigned ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned IDX_HI = OFF + SLOT_W + ROW_W;
    localparam int unsigned YW     = WEIGHT_W + $clog2(GHR_LENGTH + 2);
    localparam logic [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] WMIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef logic [GHR_LENGTH:0][WEIGHT_W-1:0] pw_t;

    function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic up);
        if (up) return (w == WMAX) ? w : w + WEIGHT_W'(1);
        else    return (w == WMIN) ? w : w - WEIGHT_W'(1);
    endfunction

    pw_t                   weights [ROWS][INSTR_PER_FETCH];
    logic [GHR_LENGTH-1:0] sghr, cghr;

    // prediction path
    logic [ROW_W-1:0]      pred_row;
    logic signed [YW-1:0]  y_pred [INSTR_PER_FETCH];

    assign pred_row = vpc_i[IDX_HI-1 : OFF+SLOT_W];

    for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_pred
        perceptron_dot #(.H(GHR_LENGTH), .W(WEIGHT_W), .YW(YW)) i_pred_dot (
            .weights (weights[pred_row][s]),
            .hist    (sghr),
            .y       (y_pred[s])
        );
        assign bht_prediction_o[s].valid = 1'b1;
        assign bht_prediction_o[s].taken = (y_pred[s] > 0);
    end

    // U1 stage: update entry
    logic                  upd_en;
    logic [ROW_W-1:0]      upd_row;
    logic [SLOT_W-1:0]     upd_slot;
    logic                  u1_valid, u1_taken, u1_mispredict;
    logic [ROW_W-1:0]      u1_row;
    logic [SLOT_W-1:0]     u1_slot;
    logic [GHR_LENGTH-1:0] u1_hist;
    pw_t                   u1_w;

    assign upd_en   = bht_update_i.valid && !debug_mode_i;
    assign upd_row  = bht_update_i.pc[IDX_HI-1 : OFF+SLOT_W];
    assign upd_slot = bht_update_i.pc[OFF+SLOT_W-1 : OFF];

    // U2 stage: recompute, decide, write back
    logic signed [YW-1:0]  y_train;
    logic [YW-1:0]         y_abs;
    logic                  train;
    pw_t                   new_w;

    perceptron_dot #(.H(GHR_LENGTH), .W(WEIGHT_W), .YW(YW)) i_train_dot (
        .weights (u1_w),
        .hist    (u1_hist),
        .y       (y_train)
    );

    assign y_abs = y_train[YW-1] ? -y_train : y_train;
    assign train = u1_valid && (u1_mispredict || (y_abs <= YW'(THETA)));

    always_comb begin
        new_w    = u1_w;
        new_w[0] = sat_step(u1_w[0], u1_taken);
        for (int unsigned i = 1; i <= GHR_LENGTH; i++) begin
            new_w[i] = sat_step(u1_w[i], u1_taken == u1_hist[i-1]);
        end
    end

    // U1 forwards the U2 result when both stages hit the same perceptron
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            u1_valid      <= 1'b0;
            u1_taken      <= 1'b0;
            u1_mispredict <= 1'b0;
            u1_row        <= '0;
            u1_slot       <= '0;
            u1_hist       <= '0;
            u1_w          <= '0;
        end else begin
            u1_valid <= upd_en;
            if (upd_en) begin
                u1_taken      <= bht_update_i.taken;
                u1_mispredict <= bht_update_i.mispredict;
                u1_row        <= upd_row;
                u1_slot       <= upd_slot;
                u1_hist       <= cghr;
                u1_w          <= (train && u1_row == upd_row && u1_slot == upd_slot)
                                 ? new_w : weights[upd_row][upd_slot];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
                    weights[r][s] <= '0;
                end
            end
        end else if (train) begin
            weights[u1_row][u1_slot] <= new_w;
        end
    end

    // history registers: mispredict beats flush beats speculative shift
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sghr <= '0;
            cghr <= '0;
        end else if (!debug_mode_i) begin
            if (bht_update_i.valid) cghr <= {cghr[GHR_LENGTH-2:0], bht_update_i.taken};
            if (bht_update_i.valid && bht_update_i.mispredict)
                sghr <= {cghr[GHR_LENGTH-2:0], bht_update_i.taken};
            else if (flush_i)
                sghr <= cghr;
            else if (spec_valid_i)
                sghr <= {sghr[GHR_LENGTH-2:0], spec_taken_i};
        end
    end

`ifdef PERCEPTRON_BHT_STATS_EN
    logic [31:0] pred_cnt, mispred_cnt, train_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_cnt    <= '0;
            mispred_cnt <= '0;
            train_cnt   <= '0;
        end else begin
            if (spec_valid_i && pred_cnt != '1) pred_cnt <= pred_cnt + 32'd1;
            if (bht_update_i.valid && bht_update_i.mispredict && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + 32'd1;
            if (train && train_cnt != '1) train_cnt <= train_cnt + 32'd1;
        end
    end

    assign stat_pred_o    = pred_cnt;
    assign stat_mispred_o = mispred_cnt;
    assign stat_train_o   = train_cnt;
`else
    assign stat_pred_o    = '0;
    assign stat_mispred_o = '0;
    assign stat_train_o   = '0;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_HI], vpc_i[OFF-1:0],
                              bht_update_i.pc[VLEN-1:IDX_HI], bht_update_i.pc[OFF-1:0]};

endmodule
